numeric_keypad_frontend: RTL
============================

# numeric_keypad_frontend

Debounced front end for the detonator's 10-key numeric keypad. It samples raw, bouncing, asynchronous key lines and produces the clean one-hot key bus `A[9:0]` that the detonator core consumes. `A` is held for as long as the key is stably pressed. Alongside `A`, the block provides a BCD digit, a one-cycle press strobe, and a multi-key error strobe. It sits between the board buttons and `numeric_code_detonator`, in the same clock domain.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a press or a release. Legal range is 2 or more.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `key_raw`  in  10  raw key lines, active-high, asynchronous. Bit i is digit i.
- `A`  out  10  debounced one-hot key bus to the detonator. All-zero means no key.
- `digit`  out  4  BCD value of the last accepted key, 0–9.
- `digit_vld`  out  1  one-cycle pulse on each accepted press.
- `err`  out  1  one-cycle pulse when two or more keys become pressed together.

## Operation
- Synchronizer: a 2-flop synchronizer on all 10 lines (`s1` then `s2`). The FSM uses only `s2`.
- Classify `s2` as exactly one of:
  - zero;
  - one-hot;
  - multi-hot (2 or more bits set).
- Registers:
  - `cand[9:0]`: candidate key.
  - `cnt`: width `$clog2(DEBOUNCE_CYCLES+1)`; saturates and never wraps.
  - `multi_q`: previous-cycle multi-hot flag.
- FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE.
- IDLE:
  - `s2` one-hot: `cand`<=`s2`, `cnt`<=1, go to DEBOUNCE.
  - Zero or multi-hot: stay in IDLE.
- DEBOUNCE:
  - `s2`==`cand`: `cnt`<=`cnt`+1.
  - When the incremented value equals `DEBOUNCE_CYCLES`: go to PRESSED, `A`<=`cand`, `digit`<=encode(`cand`), `digit_vld`<=1.
  - `s2`!=`cand`: go to IDLE with `cnt`<=0, `A` unchanged (0).
- PRESSED:
  - `A` is held.
  - `s2`!=`cand` (zero, another key, or multi-hot): `cnt`<=1, go to RELEASE.
- RELEASE:
  - `A` is still held.
  - `s2`==`cand`: return to PRESSED. This is a bounce: no new `digit_vld`.
  - `s2`!=`cand`: increment `cnt`. On reaching `DEBOUNCE_CYCLES`: go to IDLE, `A`<=0.
  - `digit` keeps its last value.
- Rollover: a new key is accepted only after the old key's release completes. It then debounces from IDLE as a fresh press.
- `err`: `err`<=(`s2` multi-hot) && !`multi_q`, in every state. It is a single pulse per multi-hot episode and has no effect on state transitions beyond those listed above.
- `A` is always zero or one-hot. It is never multi-hot.

## Timing
- Reset (`rst_n`=0 at a rising edge) clears the following at that edge, in any state, including mid-DEBOUNCE and mid-PRESSED:
  - `s1`, `s2`, `cand`, `cnt`, `multi_q`;
  - state to IDLE;
  - `A`=0, `digit`=0, `digit_vld`=0, `err`=0.
- Press latency: number the first edge that samples `key_raw` stably high as edge 1.
  - `s2` shows the key after edge 2.
  - DEBOUNCE is entered at edge 3.
  - `A`, `digit` and `digit_vld` update at edge `DEBOUNCE_CYCLES`+2. This is edge 6 for the default.
- Release latency is symmetric: `A` returns to 0 at edge `DEBOUNCE_CYCLES`+2 after the first edge that samples the key low.
- `digit_vld` is high for exactly one cycle, the same cycle `A` first becomes nonzero.
- `err` asserts 3 edges after the first edge that samples a multi-hot `key_raw`: 2 synchronizer edges plus 1 register edge.
- All outputs are registered. There is no combinational path from `key_raw`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Clean press: `key_raw`=10'b0000000100 held for 12 cycles, then 0.
  - `A`=10'b0000000100, `digit`=2, and one `digit_vld` pulse, all at edge 6.
  - `A`=0 at edge 6 after release.
  - `digit` stays 2.
- Press bounce: key 5 pattern is high 2, low 1, high 2, low 1, then high 10 cycles.
  - No `digit_vld` during the bounce.
  - `A`=10'b0000100000 and a single `digit_vld` 6 edges after the final stable rise.
- Release bounce: key 8 accepted, then raw pattern low 2, high 1, low 10.
  - `A` holds 10'b0100000000 through the glitch.
  - No second `digit_vld`.
  - `A`=0 6 edges after the final fall.
- Multi-key: `key_raw`=10'b0100000001 for 10 cycles from IDLE.
  - Exactly one `err` pulse at edge 3.
  - `A` stays 0 and there is no `digit_vld`.
- Rollover: hold 8, then 8+1 for 3 cycles, then 1 alone for 12 cycles.
  - Expected sequence on outputs:
    1. `A`=8 with `digit_vld` (`digit`=8).
    2. One `err` pulse.
    3. `A`=0.
    4. `A`=10'b0000000010, `digit`=1, with a new `digit_vld` pulse.
- Reset mid-operation: while `A`=10'b0000000100 with the key still held, `rst_n`=0 for 2 cycles.
  - `A`=0, `digit`=0 at the first reset edge.
  - After `rst_n` returns to 1, the key is re-accepted: `A`=10'b0000000100 and `digit_vld` at edge 6.

Source files
------------

// File: rtl/numeric_keypad_frontend.sv
// numeric_keypad_frontend
//   Debounced front end for the 10-key numeric keypad. Synchronizes the raw,
//   bouncing key lines, debounces press and release, and drives a clean
//   one-hot key bus for the detonator core.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   key_raw    in   [9:0] raw asynchronous key lines, bit i = digit i
//   A          out  [9:0] debounced one-hot key bus, all-zero = no key
//   digit      out  [3:0] BCD value of the last accepted key
//   digit_vld  out  one-cycle pulse on each accepted press
//   err        out  one-cycle pulse when two or more keys become pressed
module numeric_keypad_frontend #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] key_raw,
    output logic [9:0] A,
    output logic [3:0] digit,
    output logic       digit_vld,
    output logic       err
);

    localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_e;

    state_e        state_q, state_d;
    logic [9:0]    s1_q, s2_q;
    logic [9:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          multi_q;
    logic [9:0]    a_q, a_d;
    logic [3:0]    digit_q, digit_d;
    logic          vld_q, vld_d;
    logic          err_q;

    logic s2_zero, s2_onehot, s2_multi;

    function automatic logic [3:0] encode(input logic [9:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (oh[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Clearing the lowest set bit leaves zero only for a one-hot value.
    assign s2_zero   = (s2_q == '0);
    assign s2_onehot = !s2_zero && ((s2_q & (s2_q - 10'd1)) == '0);
    assign s2_multi  = !s2_zero && !s2_onehot;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        digit_d = digit_q;
        vld_d   = 1'b0;
        // Saturating increment: the counter never wraps.
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (s2_onehot) begin
                    cand_d  = s2_q;
                    cnt_d   = CNT_ONE;
                    state_d = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (s2_q == cand_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_d = S_PRESSED;
                        a_d     = cand_q;
                        digit_d = encode(cand_q);
                        vld_d   = 1'b1;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            S_PRESSED: begin
                if (s2_q != cand_q) begin
                    cnt_d   = CNT_ONE;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // A returning candidate is a release bounce, not a new press.
                if (s2_q == cand_q) begin
                    state_d = S_PRESSED;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_d = S_IDLE;
                        a_d     = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            state_q <= S_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            multi_q <= 1'b0;
            a_q     <= '0;
            digit_q <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            s1_q    <= key_raw;
            s2_q    <= s1_q;
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            multi_q <= s2_multi;
            a_q     <= a_d;
            digit_q <= digit_d;
            vld_q   <= vld_d;
            // One pulse per multi-hot episode, independent of the FSM.
            err_q   <= s2_multi && !multi_q;
        end
    end

    assign A         = a_q;
    assign digit     = digit_q;
    assign digit_vld = vld_q;
    assign err       = err_q;

endmodule
